// File: rtl/mem_bank_slave.sv
// Single memory bank on one interconnect slave port.
// Pipelined reads with held read data, sticky range error and access counters.
module mem_bank_slave #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4096,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_slave_req,
   input  logic                  i_slave_we,
   input  logic [ADDR_WIDTH-1:0] i_slave_addr,
   input  logic [DATA_WIDTH-1:0] i_slave_wdata,
   output logic [DATA_WIDTH-1:0] o_slave_rdata,
   output logic                  o_rvalid,
   output logic                  o_err,
   input  logic                  i_err_clr,
   output logic [15:0]           o_rd_count,
   output logic [15:0]           o_wr_count
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [12:0] DEPTH_W = 13'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [11:0]           idx;
   logic [AW-1:0]         widx;
   logic                  oor;
   logic                  wr_ok;
   logic                  rd_req;
   logic                  rd_ok;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  addr_unused;

   // Bits [15:14] select the slave upstream; byte offset is ignored.
   assign addr_unused = ^{i_slave_addr[ADDR_WIDTH-1:14],
                          i_slave_addr[1:0]};

   assign idx     = i_slave_addr[13:2];
   assign widx    = idx[AW-1:0];
   assign oor     = {1'b0, idx} >= DEPTH_W;
   assign wr_ok   = i_slave_req && i_slave_we && !oor;
   assign rd_req  = i_slave_req && !i_slave_we;
   assign rd_ok   = rd_req && !oor;
   assign rd_word = oor ? '0 : mem[widx];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[widx] <= i_slave_wdata;
      end
   end

   logic                  vld_q [READ_LATENCY];
   logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY];

   // Data stages load only on a valid token, so the last stage holds
   // the most recent completed read between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < READ_LATENCY; k++) begin
            vld_q[k] <= 1'b0;
            dat_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= rd_req;
         if (rd_req) begin
            dat_q[0] <= rd_word;
         end
         for (int k = 1; k < READ_LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               dat_q[k] <= dat_q[k-1];
            end
         end
      end
   end

   assign o_rvalid      = vld_q[READ_LATENCY-1];
   assign o_slave_rdata = dat_q[READ_LATENCY-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_err <= 1'b0;
      end else if (i_slave_req && oor) begin
         o_err <= 1'b1;
      end else if (i_err_clr) begin
         o_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_rd_count <= '0;
         o_wr_count <= '0;
      end else begin
         if (rd_ok && o_rd_count != 16'hFFFF) begin
            o_rd_count <= o_rd_count + 16'd1;
         end
         if (wr_ok && o_wr_count != 16'hFFFF) begin
            o_wr_count <= o_wr_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bank_slave.sv
// Randomised bench for mem_bank_slave against a queue/array reference model.
// Small bank (1024 words) so out-of-range indices are reachable.
module tb_mem_bank_slave;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic          clk;
   logic          rst_n;
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          err;
   logic          err_clr;
   logic [15:0]   rd_count;
   logic [15:0]   wr_count;

   mem_bank_slave #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .READ_LATENCY(LAT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_slave_req  (req),
      .i_slave_we   (we),
      .i_slave_addr (addr),
      .i_slave_wdata(wdata),
      .o_slave_rdata(rdata),
      .o_rvalid     (rvalid),
      .o_err        (err),
      .i_err_clr    (err_clr),
      .o_rd_count   (rd_count),
      .o_wr_count   (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_bad;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          due;
      logic [31:0] d;
   } rsp_t;

   logic [31:0] m_mem [DEPTH];
   rsp_t        m_q [$];
   int          edges;
   logic [31:0] m_rdata;
   bit          m_err;
   int          m_rd;
   int          m_wr;

   task automatic m_reset();
      m_q.delete();
      m_rdata = '0;
      m_err   = 1'b0;
      m_rd    = 0;
      m_wr    = 0;
   endtask

   task automatic chk_all(input string pfx, input bit rv);
      chk({pfx, "rvalid"}, 32'(rvalid), 32'(rv));
      chk({pfx, "rdata"}, rdata, m_rdata);
      chk({pfx, "err"}, 32'(err), 32'(m_err));
      chk({pfx, "rd_count"}, 32'(rd_count), m_rd);
      chk({pfx, "wr_count"}, 32'(wr_count), m_wr);
   endtask

   task automatic step(input bit r, input bit w,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input bit clr);
      int idx;
      bit oor;
      bit rv;
      req     = r;
      we      = w;
      addr    = a;
      wdata   = wd;
      err_clr = clr;
      @(posedge clk);
      #1;
      edges++;
      idx = int'(a[13:2]);
      oor = idx >= DEPTH;
      if (r && oor) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      if (r && !w) begin
         m_q.push_back('{edges + LAT - 1, oor ? 32'h0 : m_mem[idx]});
         if (!oor && m_rd < 65535) m_rd++;
      end
      if (r && w && !oor) begin
         m_mem[idx] = wd;
         if (m_wr < 65535) m_wr++;
      end
      rv = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == edges) begin
         rv      = 1'b1;
         m_rdata = m_q[0].d;
         void'(m_q.pop_front());
      end
      chk_all("", rv);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   function automatic logic [31:0] rand_addr(input int idx);
      logic [31:0] r;
      r = $urandom;
      return (r & 32'hFFFF_C003) | (32'(idx) << 2);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      #2;
      chk_all("rst_", 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec   = 0;
      n_bad   = 0;
      edges   = 0;
      req     = 1'b0;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;
      err_clr = 1'b0;
      m_reset();
      rst_n   = 1'b0;
      #22;
      chk_all("rst_", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill the whole bank so every read has a known expectation.
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 1'b1, rand_addr(i), $urandom, 1'b0);

      // Reset then read: contents survive reset, counters restart.
      do_reset();
      step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) idle();

      // Write then read back next cycle.
      step(1'b1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0);
      step(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) idle();
      chk("rab_data", rdata, 32'hDEAD_BEEF);

      // Pipelined burst.
      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b1, 32'(i) << 2, 32'(i * 3), 1'b0);
      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b0, 32'(i) << 2, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) idle();

      // Write while a read of the same word is in flight.
      step(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
      step(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0);
      idle();
      idle();

      // Out-of-range write, read, clear, clear-vs-set.
      step(1'b1, 1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 1'b0);
      step(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
      idle();
      idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'h0000_1FFC, 32'h1, 1'b1);
      idle();

      // Reset while a read is in flight.
      step(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) idle();

      // Random traffic including out-of-range and clears.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 4) != 0, ($urandom % 2) == 1,
              rand_addr($urandom_range(0, 1279)), $urandom,
              ($urandom % 8) == 0);
      end
      for (int i = 0; i < 4; i++) idle();

      // Read counter saturation.
      do_reset();
      for (int i = 0; i < 65537; i++)
         step(1'b1, 1'b0, rand_addr($urandom_range(0, DEPTH - 1)),
              32'h0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, rand_addr(5), 32'h0, 1'b0);
      chk("sat_rd", 32'(rd_count), 32'h0000_FFFF);
      chk("sat_wr", 32'(wr_count), 32'h0);
      for (int i = 0; i < 3; i++) idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bank_slave.md
Name: mem_bank_slave

Overview:
- Single memory bank behind one slave port of the shared interconnect; there is one instance per slave index.
- Consumes the interconnect's per-slave req/addr/wdata and returns read data on rdata.
- Read path is pipelined with a configurable latency. Read data is held stable between reads, so the interconnect's combinational rdata return always sees the last completed read.
- Provides an out-of-range error flag and saturating access counters for debug and performance monitoring.

Parameters:
- ADDR_WIDTH, 32, width of the request address.
- DATA_WIDTH, 32, width of a data word.
- DEPTH, 4096, number of DATA_WIDTH words in the bank. Must be a power of two and ≤ 4096.
- READ_LATENCY, 2, cycles from read request to o_rvalid. Legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_slave_req  input  1  request strobe from the interconnect slave port; one access per cycle when high.
- i_slave_we  input  1  1 = write, 0 = read; sampled only when i_slave_req=1; tie to 0 for read-only use.
- i_slave_addr  input  ADDR_WIDTH  byte address; word index = i_slave_addr[13:2].
- i_slave_wdata  input  DATA_WIDTH  write data.
- o_slave_rdata  output  DATA_WIDTH  read data of the most recently completed read; held until the next read completes.
- o_rvalid  output  1  single-cycle pulse when o_slave_rdata is updated.
- o_err  output  1  sticky out-of-range flag.
- i_err_clr  input  1  synchronous clear of o_err.
- o_rd_count  output  16  saturating count of accepted in-range reads.
- o_wr_count  output  16  saturating count of accepted in-range writes.

Behaviour:
- Reset: async assert on rst_n=0.
  - o_slave_rdata=0, o_rvalid=0, o_err=0, o_rd_count=0, o_wr_count=0.
  - All in-flight read pipeline stages are invalidated.
  - Array contents are not reset.
- Address decode:
  - idx = i_slave_addr[13:2]; bits [1:0] and bits above 13 are ignored (bits [15:14] are used upstream for slave select).
  - Out-of-range when idx ≥ DEPTH. With DEPTH=4096 this never occurs.
- Write (req=1, we=1, in range):
  - Array word idx is written at the rising edge of the request cycle.
  - No response; o_rvalid is not pulsed.
  - o_wr_count increments.
- Read (req=1, we=0, in range):
  - Request in cycle N produces o_rvalid=1 and new o_slave_rdata visible in cycle N+READ_LATENCY.
  - o_rd_count increments at the edge of cycle N.
- Pipelining:
  - A new request is accepted every cycle with no stalls.
  - Back-to-back reads produce back-to-back o_rvalid pulses in request order.
- Read-after-write:
  - A read issued the cycle after a write to the same idx returns the new data.
  - A write issued while an earlier read to the same idx is in flight does not affect that read's data. The array is sampled in the request cycle.
- Out-of-range:
  - Write: dropped; array unchanged.
  - Read: still produces an o_rvalid pulse at normal latency with o_slave_rdata=0.
  - Both set o_err at the edge of the request cycle; neither counter changes.
- o_err clear:
  - i_err_clr=1 clears o_err at the next edge.
  - If a new error occurs in the same cycle as i_err_clr, set wins and o_err stays 1.
- Counters: 16-bit, saturate at 16'hFFFF and never wrap.
- o_slave_rdata: changes only on the cycle o_rvalid=1; writes never modify it.
- i_slave_we, i_slave_addr, i_slave_wdata: ignored when i_slave_req=0.

Test Plan:
- Reset then read: reset released, read addr 0x0000_0010 → o_rvalid pulses exactly 2 cycles later (READ_LATENCY=2); o_rd_count=1; o_slave_rdata held after the pulse.
- Write/read-back: write 0xDEADBEEF to addr 0x0000_0104, read the same addr next cycle → rdata=0xDEADBEEF 2 cycles after the read; o_wr_count=1, o_rd_count=1.
- Pipelined burst: write idx 0..7 with value idx*3, then 8 consecutive reads → 8 consecutive o_rvalid pulses with rdata 0,3,...,21 in order, no gaps.
- Out-of-range (DEPTH=1024): write to addr 0x0000_1000 (idx 1024) → array unchanged; o_err=1; o_wr_count unchanged. A read of the same addr → rvalid with rdata=0. Assert i_err_clr alone → o_err=0. Assert i_err_clr together with a new OOR request → o_err stays 1.
- Reset mid-read: issue a read, assert rst_n=0 one cycle later → no o_rvalid pulse after release; all outputs 0.
- Saturation: force 65 537 reads → o_rd_count=16'hFFFF and stays; o_wr_count=0.
